// File: rtl/clm_rand_feeder.sv
// Double-buffered random-vector feeder for a masked multiplier.
// A Galois LFSR fills the back bank d bits per cycle, and an honoured req swaps the back bank into the front bank.
module clm_rand_feeder #(
  parameter int d = 2,
  localparam int N = 2 * (8 + d)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   seed_valid,
  input  logic [31:0]            seed,
  input  logic                   req,
  output logic [0:N-1][d-1:0]    random_vect,
  output logic                   vect_ready,
  output logic                   underflow,
  output logic [15:0]            vect_count
);

  localparam int          IW   = $clog2(N);
  localparam logic [31:0] POLY = 32'h8020_0003;

  typedef enum logic [1:0] {UNSEEDED, FILL, FULL} state_t;

  state_t               state_reg, state_next;
  logic [31:0]          lfsr_reg, lfsr_next;
  logic [IW-1:0]        index_reg;
  logic [0:N-1][d-1:0]  back_reg, front_reg;
  logic [15:0]          count_reg;
  logic                 underflow_reg;
  logic [d-1:0]         word_next;
  logic                 honour;

  assign honour = req & vect_ready;

  // d unrolled LFSR steps per cycle; bit j of the word is the output of step j
  always_comb begin
    lfsr_next = lfsr_reg;
    word_next = '0;
    for (int j = 0; j < d; j++) begin
      word_next[j] = lfsr_next[0];
      lfsr_next    = (lfsr_next >> 1) ^ (lfsr_next[0] ? POLY : 32'h0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state_reg <= UNSEEDED;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      UNSEEDED: if (seed_valid) state_next = FILL;
      FILL: begin
        if (seed_valid)                        state_next = FILL;
        else if (index_reg == IW'(N - 1))      state_next = FULL;
      end
      FULL:     if (seed_valid || honour) state_next = FILL;
      default:  state_next = UNSEEDED;
    endcase
  end

  always_comb begin
    vect_ready = (state_reg == FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr_reg      <= '0;
      index_reg     <= '0;
      back_reg      <= '0;
      front_reg     <= '0;
      count_reg     <= '0;
      underflow_reg <= 1'b0;
    end else begin
      if (seed_valid)
        lfsr_reg <= (seed == 32'h0) ? 32'h0000_0001 : seed;
      else if (state_reg == FILL)
        lfsr_reg <= lfsr_next;

      // A reseed discards the partial fill, so no write happens on that edge
      if (seed_valid || honour)
        index_reg <= '0;
      else if (state_reg == FILL)
        index_reg <= (index_reg == IW'(N - 1)) ? '0 : index_reg + 1'b1;

      if (state_reg == FILL && !seed_valid)
        back_reg[index_reg] <= word_next;

      if (honour) begin
        front_reg <= back_reg;
        if (count_reg != 16'hFFFF) count_reg <= count_reg + 16'd1;
      end

      if (req && !vect_ready)
        underflow_reg <= 1'b1;
    end
  end

  assign random_vect = front_reg;
  assign underflow   = underflow_reg;
  assign vect_count  = count_reg;

endmodule

// File: tb/tb_clm_rand_feeder.sv
// Scoreboard bench for clm_rand_feeder: a stream-level model predicts per-cycle status and every delivered vector.
module tb_clm_rand_feeder;

  localparam int          D    = 2;
  localparam int          N    = 2 * (8 + D);
  localparam logic [31:0] POLY = 32'h8020_0003;

  typedef logic [0:N-1][D-1:0] vec_t;
  typedef struct { logic ready; logic uf; logic [15:0] count; vec_t front; } status_t;
  typedef struct { vec_t front; logic [15:0] count; } swap_t;

  logic        clk;
  logic        rst;
  logic        seed_valid;
  logic [31:0] seed;
  logic        req;
  vec_t        random_vect;
  logic        vect_ready;
  logic        underflow;
  logic [15:0] vect_count;

  clm_rand_feeder #(.d(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .seed_valid  (seed_valid),
    .seed        (seed),
    .req         (req),
    .random_vect (random_vect),
    .vect_ready  (vect_ready),
    .underflow   (underflow),
    .vect_count  (vect_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  status_t status_q[$];
  swap_t   swap_q[$];
  int      errors = 0;
  int      checks = 0;

  // Reference model: a fill is simply the next 2N bits of the LFSR stream, ready N edges after it starts
  logic        m_seeded;
  int          m_left;
  logic [31:0] m_lfsr;
  vec_t        m_pending, m_front;
  logic [15:0] m_count;
  logic        m_uf;

  function automatic logic m_bit();
    logic b;
    b = m_lfsr[0];
    m_lfsr = (m_lfsr >> 1) ^ (b ? POLY : 32'h0);
    return b;
  endfunction

  function automatic void m_start_fill();
    for (int w = 0; w < N; w++)
      for (int j = 0; j < D; j++)
        m_pending[w][j] = m_bit();
    m_left = N;
  endfunction

  function automatic logic m_ready();
    return m_seeded && (m_left == 0);
  endfunction

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic step(input logic r, input logic sv, input logic [31:0] sd, input logic rq);
    logic hon;
    @(negedge clk);
    rst = r; seed_valid = sv; seed = sd; req = rq;
    if (!r) begin
      m_seeded = 1'b0; m_left = 0; m_lfsr = '0; m_pending = '0;
      m_front = '0; m_count = '0; m_uf = 1'b0;
    end else begin
      hon = rq && m_ready();
      if (rq && !m_ready()) m_uf = 1'b1;
      if (hon) begin
        m_front = m_pending;
        if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
        swap_q.push_back('{front: m_pending, count: m_count});
      end
      if (sv) begin
        m_lfsr   = (sd == 32'h0) ? 32'h1 : sd;
        m_seeded = 1'b1;
        m_start_fill();
      end else if (hon) begin
        m_start_fill();
      end else if (m_left > 0) begin
        m_left--;
      end
    end
    status_q.push_back('{ready: m_ready(), uf: m_uf, count: m_count, front: m_front});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  // Monitor: per-cycle status plus one scoreboard entry per observed handshake
  initial begin
    status_t st;
    swap_t   sw;
    logic    hs;
    forever begin
      @(posedge clk);
      hs = rst && req && vect_ready;
      #1;
      if (status_q.size() > 0) begin
        st = status_q.pop_front();
        chk("vect_ready", 64'(vect_ready), 64'(st.ready));
        chk("underflow",  64'(underflow),  64'(st.uf));
        chk("vect_count", 64'(vect_count), 64'(st.count));
        chk("front",      64'(random_vect), 64'(st.front));
      end
      if (hs) begin
        if (swap_q.size() == 0) begin
          chk("unexpected_swap", 64'(1), 64'(0));
        end else begin
          sw = swap_q.pop_front();
          chk("swap_vect",  64'(random_vect), 64'(sw.front));
          chk("swap_count", 64'(vect_count),  64'(sw.count));
        end
      end
    end
  end

  initial begin
    rst = 1'b0; seed_valid = 1'b0; seed = '0; req = 1'b0;
    m_seeded = 1'b0; m_left = 0; m_lfsr = '0; m_pending = '0;
    m_front = '0; m_count = '0; m_uf = 1'b0;

    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0);

    // Seed 1: ready after N+1 cycles, first word 2'b11
    step(1'b1, 1'b1, 32'h1, 1'b0);
    idle(N);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    idle(1);
    chk("seed1_word0", 64'(random_vect[0]), 64'(2'b11));

    // Seed 0 behaves as seed 1; early req raises underflow only
    step(1'b1, 1'b1, 32'h0, 1'b0);
    idle(4);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    idle(N);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    idle(1);
    chk("seed0_word0", 64'(random_vect[0]), 64'(2'b11));

    // Reset while FULL, then a req on the next cycle
    idle(N);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1);

    // Reseed mid-fill at index 10
    step(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
    idle(10);
    step(1'b1, 1'b1, 32'h1234_5678, 1'b0);
    idle(N);
    // Reseed together with an honoured req
    step(1'b1, 1'b1, 32'hCAFE_F00D, 1'b1);
    idle(N);

    // Back-to-back delivery of 10 vectors
    for (int v = 0; v < 10; v++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1);
      idle(N);
    end

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic        r, sv, rq;
      logic [31:0] sd;
      r  = ($urandom_range(0, 299) != 0);
      sv = ($urandom_range(0, 63) == 0);
      sd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      rq = m_ready() ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 31) == 0);
      step(r, sv, sd, rq);
    end
    idle(1);

    @(posedge clk);
    #2;
    chk("swap_q_drained",   64'(swap_q.size()),   64'(0));
    chk("status_q_drained", 64'(status_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clm_rand_feeder.md
CLM_RAND_FEEDER -- requirements
Module: clm_rand_feeder

Interface
REQ-001 Parameter d SHALL be declared: default 2; number of redundancy bits per masked element (state width 8+d).
REQ-002 Derived constant N SHALL be 2*(8+d), the number of d-bit random words per multiplication (N=20 at d=2).
REQ-003 Port clk  in  1: sole clock, rising-edge.
REQ-004 Port rst  in  1: synchronous, active-low reset.
REQ-005 Port seed_valid  in  1: load seed into the PRNG this cycle.
REQ-006 Port seed  in  32: PRNG seed value.
REQ-007 Port req  in  1: single-cycle pulse from the consumer, asserted in the same cycle as the multiplier's drdy_i; takes the next vector.
REQ-008 Port random_vect  out  N x d (red_poly_t[0:N-1]): front bank, fed to the multiplier random input.
REQ-009 Port vect_ready  out  1: back bank is full; a req this cycle is honoured.
REQ-010 Port underflow  out  1: sticky flag, a req arrived with vect_ready=0.
REQ-011 Port vect_count  out  16: number of vectors delivered, saturating at 16'hFFFF.

Function
REQ-012 The PRNG SHALL be a 32-bit Galois LFSR stepping right: out=lfsr[0]; lfsr=(lfsr>>1)^(out ? 32'h80200003 : 0).
REQ-013 A seed of 32'h0 SHALL be loaded as 32'h0000_0001 (no lock-up state).
REQ-014 The block SHALL hold two banks of N d-bit words: front (drives random_vect) and back (being filled).
REQ-015 FSM states SHALL be UNSEEDED, FILL, FULL; reset enters UNSEEDED.
REQ-016 UNSEEDED: no LFSR stepping; seed_valid -> load LFSR, fill index=0, go to FILL.
REQ-017 FILL: each cycle the LFSR SHALL advance d steps (unrolled), word bit j = output bit of step j, written to back[index], index+1.
REQ-018 FILL: the write at index N-1 SHALL go to FULL; vect_ready=1 from the next cycle.
REQ-019 FULL: the LFSR SHALL hold; vect_ready=1.
REQ-020 req while vect_ready=1: at that edge front<=back, index<=0, state<=FILL, vect_count+1 (saturating).
REQ-021 The front bank SHALL change only on an honoured req; it is stable during the 8+d multiplier cycles that follow.
REQ-022 req while vect_ready=0: front, index and state unchanged; underflow<=1 and stays set until reset.
REQ-023 seed_valid in FILL or FULL: reload LFSR, discard back contents (index=0, state FILL, vect_ready=0 next cycle); front is untouched.
REQ-024 seed_valid together with an honoured req: swap and count happen as in REQ-020; the refill SHALL use the new seed.
REQ-025 Fill latency: vect_ready SHALL rise exactly N+1 cycles after the cycle in which seed_valid or an honoured req is sampled.
REQ-026 A word SHALL never be delivered twice: every word of a delivered front bank was produced after the previous swap.

Reset
REQ-027 rst=0 at a rising edge SHALL force: state UNSEEDED, LFSR=0, index=0, both banks all-zero, vect_ready=0, underflow=0, vect_count=0.
REQ-028 Reset SHALL take priority over seed_valid and req in the same cycle; reset during FILL discards the partial fill.

Verification
REQ-029 d=2, reset, seed=32'h1 at cycle 0 -> vect_ready=0 through cycle 20, =1 at cycle 21; after a req, random_vect[0]=2'b11 and LFSR state after word 0 = 32'hC0300002.
REQ-030 seed=32'h0 -> bit stream identical to seed=32'h1.
REQ-031 req at cycle 5 while filling -> underflow=1 from cycle 6, random_vect and vect_count unchanged, fill completes on schedule.
REQ-032 Back-to-back: req at the first vect_ready cycle, then every 21 cycles for 10 vectors -> vect_count=10, underflow=0, front stable for 20 cycles after each swap, no repeated word sequence versus a reference LFSR model.
REQ-033 seed_valid at index 10 mid-fill -> index restarts at 0, vect_ready rises 21 cycles later, contents match the new seed only.
REQ-034 rst=0 for one cycle while FULL -> all outputs return to reset values; a req the next cycle sets underflow=1.
